// File: rtl/lamp_sequence_scheduler.sv
// lamp_sequence_scheduler: single-clock sequencer for the lamp-pattern datapath.
// A free-running prescaler issues rate-selectable ticks; a mode FSM steps the
// selected pattern (OFF / CHASE / HAZARD / WALK) on each tick. Mode changes
// arrive over a valid/ready handshake and are applied only at sequence
// boundaries, so a sweep is never cut short.
// Optional feature macro: BRAKE_EN (adds the brake input, which forces all
// lamps on and freezes the sequence while held).

module lamp_sequence_scheduler #(
  parameter int PRESCALE_W = 13,
  parameter int NLAMP      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       rate_sel,
  input  logic             pause,
  input  logic [1:0]       mode_req,
  input  logic             mode_valid,
  output logic             mode_ready,
  output logic [NLAMP-1:0] lamps,
  output logic             tick,
  output logic [3:0]       phase,
  output logic             busy
`ifdef BRAKE_EN
  ,
  input  logic             brake
`endif
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_HAZARD = 2'd2,
    MODE_WALK   = 2'd3
  } mode_t;

  logic [PRESCALE_W-1:0] presc_q;
  logic [PRESCALE_W-1:0] term_mask;
  logic                  brake_i;
  logic                  hold;
  logic                  term;
  logic                  boundary;
  logic                  apply;
  logic                  accept;

  mode_t                 mode_q, mode_d;
  logic [3:0]            phase_q, phase_d;
  logic                  pend_valid_q, pend_valid_d;
  mode_t                 pend_mode_q, pend_mode_d;
  logic [NLAMP-1:0]      lamps_q, lamps_d;
  logic                  tick_q;

`ifdef BRAKE_EN
  assign brake_i = brake;
`else
  assign brake_i = 1'b0;
`endif

  // Last phase index of each mode's sequence; reaching it on a tick is a boundary.
  function automatic logic [3:0] last_phase(input mode_t m);
    case (m)
      MODE_CHASE:  last_phase = 4'(2 * NLAMP - 1);
      MODE_HAZARD: last_phase = 4'd1;
      MODE_WALK:   last_phase = 4'(NLAMP - 1);
      default:     last_phase = 4'd0;
    endcase
  endfunction

  // Lamp pattern for a given mode and phase.
  function automatic logic [NLAMP-1:0] pattern(input mode_t m, input logic [3:0] p);
    logic [NLAMP-1:0] v;
    v = '0;
    for (int i = 0; i < NLAMP; i++) begin
      case (m)
        MODE_CHASE: begin
          if (int'(p) <= NLAMP) v[i] = (i < int'(p));
          else                  v[i] = (i >= int'(p) - NLAMP);
        end
        MODE_HAZARD: v[i] = (p == 4'd1);
        MODE_WALK:   v[i] = (int'(p) == i);
        default:     v[i] = 1'b0;
      endcase
    end
    return v;
  endfunction

  // Brake behaves like pause for the prescaler and the sequence.
  assign hold      = pause | brake_i;
  // Terminal count: low (PRESCALE_W - rate_sel) bits all ones.
  assign term_mask = {PRESCALE_W{1'b1}} >> rate_sel;
  assign term      = !hold && ((presc_q & term_mask) == term_mask);
  assign boundary  = term && (phase_q == last_phase(mode_q));

  // Handshake: a request transfers on a cycle where mode_valid and mode_ready
  // are both high; mode_ready is low exactly while a request is pending, and
  // the requester must hold mode_req stable while mode_valid is high.
  assign accept    = mode_valid && !pend_valid_q;
  // From OFF a pending request applies at once; otherwise only at a boundary.
  // The accept and apply never coincide because apply needs a pending request.
  assign apply     = pend_valid_q && !brake_i && ((mode_q == MODE_OFF) || boundary);

  // Next-state logic for mode, phase, pending slot and lamp drive.
  always_comb begin
    mode_d       = mode_q;
    phase_d      = phase_q;
    pend_valid_d = pend_valid_q;
    pend_mode_d  = pend_mode_q;
    if (apply) begin
      mode_d       = pend_mode_q;
      phase_d      = 4'd0;
      pend_valid_d = 1'b0;
    end else if (term) begin
      phase_d = (phase_q == last_phase(mode_q)) ? 4'd0 : phase_q + 4'd1;
    end
    if (accept) begin
      pend_valid_d = 1'b1;
      pend_mode_d  = mode_t'(mode_req);
    end
    lamps_d = brake_i ? {NLAMP{1'b1}} : pattern(mode_d, phase_d);
  end

  // State registers; reset overrides pause and brake.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      mode_q       <= MODE_OFF;
      phase_q      <= 4'd0;
      pend_valid_q <= 1'b0;
      pend_mode_q  <= MODE_OFF;
      lamps_q      <= '0;
      tick_q       <= 1'b0;
    end else begin
      presc_q      <= hold ? presc_q : presc_q + 1'b1;
      mode_q       <= mode_d;
      phase_q      <= phase_d;
      pend_valid_q <= pend_valid_d;
      pend_mode_q  <= pend_mode_d;
      lamps_q      <= lamps_d;
      tick_q       <= term;
    end
  end

  assign lamps      = lamps_q;
  assign phase      = phase_q;
  assign tick       = tick_q;
  assign mode_ready = !pend_valid_q;
  assign busy       = (mode_q != MODE_OFF) || pend_valid_q;

endmodule
